// File: rtl/fifo_word_packer_pkg.sv
// Shared types and default sizing for the FIFO byte-to-word packer.
package fifo_word_packer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_WORD_BYTES = 16;
  localparam int DEF_TIMEOUT    = 256;

endpackage

// File: rtl/fifo_word_packer.sv
// Packs bytes read from an upstream FIFO into WORD_BYTES-wide words,
// lane 0 first, and presents them on a valid/ready output. Partial words
// leave on flush. Define PACKER_TIMEOUT_EN to also close a partial word
// after TIMEOUT idle cycles.
module fifo_word_packer
  import fifo_word_packer_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int WORD_BYTES = DEF_WORD_BYTES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fifo_empty,
  output logic                            fifo_rd_en,
  input  logic [DATA_W-1:0]               fifo_rd_data,
  input  logic                            flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_W*WORD_BYTES-1:0]    out_data,
  output logic [$clog2(WORD_BYTES):0]     out_bytes,
  output logic                            out_last
);

  localparam int CNT_W  = $clog2(WORD_BYTES) + 1;
  localparam int LANE_W = $clog2(WORD_BYTES);
  localparam logic [CNT_W-1:0] LAST_L = CNT_W'(WORD_BYTES - 1);
  localparam logic [CNT_W:0]   WB_L   = (CNT_W + 1)'(WORD_BYTES);
  localparam logic [CNT_W-1:0] ONE_L  = CNT_W'(1);

  state_t                        state_r;
  state_t                        next_state_s;
  logic [CNT_W-1:0]              cnt_r;
  logic                          rd_pend_r;
  logic                          flush_pend_r;
  logic [DATA_W*WORD_BYTES-1:0]  out_data_r;
  logic [CNT_W-1:0]              out_bytes_r;
  logic                          out_valid_r;
  logic                          out_last_r;
  logic                          room_s;
  logic                          rd_en_s;
  logic                          flush_eff_s;
  logic                          close_full_s;
  logic                          close_flush_s;
  logic                          timeout_s;
  logic [LANE_W-1:0]             lane_s;

  // Bytes already landed plus the one in flight must leave room for another.
  assign room_s  = ({1'b0, cnt_r} + {{CNT_W{1'b0}}, rd_pend_r}) < WB_L;
  // Reads are held off during reset, while a word is held, and while a flush is pending.
  assign rd_en_s = (state_r != HOLD) && !fifo_empty && !flush_pend_r && room_s && !rst;
  assign lane_s  = cnt_r[LANE_W-1:0];
  assign flush_eff_s = flush_pend_r || flush || timeout_s;

`ifdef PACKER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] timer_r;
  logic             tmr_run_s;

  assign tmr_run_s = (state_r == FILL) && (cnt_r != {CNT_W{1'b0}}) && !rd_en_s;
  assign timeout_s = tmr_run_s && (timer_r == TMR_W'(TIMEOUT - 1));

  // Idle timer: counts partial-word cycles without a read, restarts on any read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r <= {TMR_W{1'b0}};
    end else if (!tmr_run_s || timeout_s) begin
      timer_r <= {TMR_W{1'b0}};
    end else begin
      timer_r <= timer_r + TMR_W'(1);
    end
  end
`else
  // Timer compiled out; this term is constant low.
  assign timeout_s = (TIMEOUT < 0);
`endif

  // Next-state and word-close decisions.
  always_comb begin
    next_state_s  = state_r;
    close_full_s  = 1'b0;
    close_flush_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (rd_en_s) next_state_s = FILL;
        else         next_state_s = IDLE;
      end
      FILL: begin
        if (rd_pend_r && (cnt_r == LAST_L)) begin
          close_full_s = 1'b1;
          next_state_s = HOLD;
        end else if (flush_eff_s && !rd_pend_r && (cnt_r != {CNT_W{1'b0}}) && !rd_en_s) begin
          close_flush_s = 1'b1;
          next_state_s  = HOLD;
        end else begin
          next_state_s = FILL;
        end
      end
      HOLD: begin
        if (out_ready) next_state_s = IDLE;
        else           next_state_s = HOLD;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= next_state_s;
  end

  // Lane filling, word closing, flush bookkeeping and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r        <= {CNT_W{1'b0}};
      rd_pend_r    <= 1'b0;
      flush_pend_r <= 1'b0;
      out_data_r   <= {(DATA_W*WORD_BYTES){1'b0}};
      out_bytes_r  <= {CNT_W{1'b0}};
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
    end else begin
      rd_pend_r <= rd_en_s;
      case (state_r)
        IDLE, FILL: begin
          if (rd_pend_r) begin
            out_data_r[DATA_W*lane_s +: DATA_W] <= fifo_rd_data;
            cnt_r <= cnt_r + ONE_L;
          end
          if (close_full_s || close_flush_s) begin
            out_valid_r  <= 1'b1;
            out_bytes_r  <= cnt_r + {{(CNT_W-1){1'b0}}, rd_pend_r};
            out_last_r   <= close_flush_s ? 1'b1 : flush_eff_s;
            flush_pend_r <= 1'b0;
          end else if (flush || timeout_s) begin
            flush_pend_r <= 1'b1;
          end else if (flush_pend_r && (cnt_r == {CNT_W{1'b0}}) && !rd_pend_r) begin
            // Nothing collected and nothing in flight: the flush has no word to close.
            flush_pend_r <= 1'b0;
          end else begin
            flush_pend_r <= flush_pend_r;
          end
        end
        HOLD: begin
          if (flush) flush_pend_r <= 1'b1;
          if (out_ready) begin
            out_valid_r <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            out_data_r  <= {(DATA_W*WORD_BYTES){1'b0}};
            out_bytes_r <= {CNT_W{1'b0}};
            out_last_r  <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          cnt_r       <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign fifo_rd_en = rd_en_s;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_bytes  = out_bytes_r;
  assign out_last   = out_last_r;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed self-checking bench for fifo_word_packer (4 x 8-bit lanes, TIMEOUT 8).
module tb_fifo_word_packer;

  localparam int DW = 8;
  localparam int WB = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_last;

  int checks = 0;
  int errors = 0;

  logic [7:0]  fmem [0:31];
  logic [4:0]  wr_ptr = 5'd0;
  logic [4:0]  rd_ptr = 5'd0;

  int          cyc = 0;
  int          first_rd = -1;
  int          last_rd = -1;
  bit          rd_in_hold = 1'b0;
  int          cap_n = 0;
  logic [31:0] cap_data  [0:15];
  logic [2:0]  cap_bytes [0:15];
  logic        cap_last  [0:15];
  int          cap_cyc   [0:15];

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  fifo_word_packer #(.DATA_W(DW), .WORD_BYTES(WB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_bytes(out_bytes),
    .out_last(out_last)
  );

  // Upstream FIFO model (one-cycle read latency) and output word capture.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= fmem[rd_ptr];
      rd_ptr       <= rd_ptr + 5'd1;
      last_rd      <= cyc;
      if (first_rd < 0) first_rd <= cyc;
    end
    if (out_valid && fifo_rd_en) rd_in_hold <= 1'b1;
    if (out_valid && out_ready && cap_n < 16) begin
      cap_data[cap_n]  <= out_data;
      cap_bytes[cap_n] <= out_bytes;
      cap_last[cap_n]  <= out_last;
      cap_cyc[cap_n]   <= cyc;
      cap_n            <= cap_n + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fmem[wr_ptr] = b;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  task automatic wait_words(input int n, input string tag);
    int k = 0;
    while (cap_n < n && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(cap_n), 64'(n));
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push(8'(i));
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data",  64'(out_data),  64'd0);
    check("rst_bytes", 64'(out_bytes), 64'd0);
    check("rst_last",  64'(out_last),  64'd0);
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    rst = 1'b0;

    // Full word, free-flowing consumer.
    wait_words(1, "w1_seen");
    check("w1_data",    64'(cap_data[0]),  64'h04030201);
    check("w1_bytes",   64'(cap_bytes[0]), 64'd4);
    check("w1_last",    64'(cap_last[0]),  64'd0);
    check("w1_latency", 64'(cap_cyc[0] - first_rd), 64'd5);

    // Partial word closed by flush.
    push(8'h0A); push(8'h0B);
    repeat (6) @(negedge clk);
    pulse_flush();
    wait_words(2, "w2_seen");
    check("w2_data",  64'(cap_data[1]),  64'h00000B0A);
    check("w2_bytes", 64'(cap_bytes[1]), 64'd2);
    check("w2_last",  64'(cap_last[1]),  64'd1);

    // Back-pressure: word held stable, no reads while held.
    out_ready = 1'b0;
    for (int i = 8'h11; i <= 8'h18; i++) push(8'(i));
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("w3_hold_seen", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("w3_stable_data",  64'(out_data),  64'h14131211);
      check("w3_stable_bytes", 64'(out_bytes), 64'd4);
    end
    out_ready = 1'b1;
    wait_words(4, "w3_w4_seen");
    check("w3_data",  64'(cap_data[2]), 64'h14131211);
    check("w4_data",  64'(cap_data[3]), 64'h18171615);
    check("w4_last",  64'(cap_last[3]), 64'd0);

    // Flush with nothing collected is dropped.
    repeat (2) @(negedge clk);
    pulse_flush();
    repeat (6) @(negedge clk);
    check("w5_no_word", 64'(cap_n), 64'd4);
    check("w5_no_valid", 64'(out_valid), 64'd0);
    for (int i = 8'h21; i <= 8'h24; i++) push(8'(i));
    wait_words(5, "w5_seen");
    check("w5_data",  64'(cap_data[4]),  64'h24232221);
    check("w5_bytes", 64'(cap_bytes[4]), 64'd4);
    check("w5_last",  64'(cap_last[4]),  64'd0);

    // Reset mid-word discards collected bytes.
    push(8'h31); push(8'h32);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_data",  64'(out_data),  64'd0);
    check("mid_rst_bytes", 64'(out_bytes), 64'd0);
    check("mid_rst_last",  64'(out_last),  64'd0);
    rst = 1'b0;
    for (int i = 8'h41; i <= 8'h44; i++) push(8'(i));
    wait_words(6, "w6_seen");
    check("w6_data",  64'(cap_data[5]),  64'h44434241);
    check("w6_bytes", 64'(cap_bytes[5]), 64'd4);

    // Idle partial word: timeout closes it, otherwise it waits for flush.
    push(8'h51); push(8'h52); push(8'h53);
`ifdef PACKER_TIMEOUT_EN
    wait_words(7, "w7_seen");
    check("w7_delay", 64'(cap_cyc[6] - last_rd), 64'd9);
`else
    repeat (40) @(negedge clk);
    check("w7_no_timeout", 64'(cap_n), 64'd6);
    pulse_flush();
    wait_words(7, "w7_seen");
`endif
    check("w7_data",  64'(cap_data[6]),  64'h00535251);
    check("w7_bytes", 64'(cap_bytes[6]), 64'd3);
    check("w7_last",  64'(cap_last[6]),  64'd1);

    check("no_rd_in_hold", 64'(rd_in_hold), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
